// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM
// state encoding and the nibble-counter width helper.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  // Never returns less than 1, so a single-nibble build still has a counter.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_rbs_4bit.sv
// Combinational 4-bit ripple-borrow subtractor: {bout, diff} = a - b - bin,
// built as a chain of full-subtractor cells.
module rbs_4bit
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] diff,
  output logic                bout
);

  logic [NIBBLE_W:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b - bin), one nibble per clock
// through a single shared ripple-borrow stage with a registered borrow.
//
// state | meaning
// IDLE  | ready; start latches a, b, bin and clears the nibble counter
// BUSY  | one nibble per edge; last nibble publishes diff/bout/ovf and pulses done
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             done
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t              state;
  logic [WIDTH-1:0]    a_reg, b_reg, shadow, shadow_next;
  logic [CW-1:0]       count;
  logic                borrow_reg, borrow_next;
  logic [NIBBLE_W-1:0] a_nib, b_nib, nib;

  always_comb begin
    a_nib       = '0;
    b_nib       = '0;
    shadow_next = shadow;
    for (int i = 0; i < NIBBLES; i++) begin
      if (count == CW'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
        shadow_next[i*NIBBLE_W +: NIBBLE_W] = nib;
      end
    end
  end

  rbs_4bit u_rbs (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (borrow_reg),
    .diff (nib),
    .bout (borrow_next)
  );

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      shadow     <= '0;
      count      <= '0;
      borrow_reg <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            count      <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          shadow     <= shadow_next;
          borrow_reg <= borrow_next;
          if (count == LAST) begin
            // shadow_next already holds the final nibble, so publish it directly
            diff  <= shadow_next;
            bout  <= borrow_next;
            ovf   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (shadow_next[WIDTH-1] != a_reg[WIDTH-1]);
            done  <= 1'b1;
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16): latency, arithmetic
// corner cases, start/ready handshake and asynchronous reset mid-operation.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        ready, busy, bout, ovf, done;
  logic [15:0] diff;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .done  (done)
  );

  task automatic test_reset();
    #1;
    checks++;
    if ({diff, bout, ovf, done} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: diff=%h bout=%b ovf=%b done=%b, want all 0", diff, bout, ovf, done);
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: ready=%b busy=%b, want 1/0", ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full op: start accepted at E0, done expected only after E4.
  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
    logic [15:0] prev;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    prev = diff;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: ready=%b busy=%b done=%b, want 0/1/0", nm, ready, busy, done);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || done !== 1'b0 || diff !== prev) begin
        failures++;
        $display("FAIL %s_busy_e%0d: ready=%b done=%b diff=%h, want 0/0/%h", nm, k, ready, done, diff, prev);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b ready=%b, want 1/1", nm, done, ready);
    end
    checks++;
    if (diff !== ed || bout !== eb || ovf !== eo) begin
      failures++;
      $display("FAIL %s_result: diff=%h bout=%b ovf=%b, want %h/%b/%b", nm, diff, bout, ovf, ed, eb, eo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || diff !== ed) begin
      failures++;
      $display("FAIL %s_after: done=%b diff=%h, want 0/%h", nm, done, diff, ed);
    end
  endtask

  task automatic test_arith();
    run_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("ripple",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_op("bin_nib",  16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;             // E0
    start = 1'b0;
    @(posedge clk); #1;             // E1
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;             // E2: start while busy
    start = 1'b0;
    @(posedge clk); #1;             // E3
    @(posedge clk); #1;             // E4
    checks++;
    if (done !== 1'b1 || diff !== 16'h1000 || bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: done=%b diff=%h bout=%b ovf=%b, want 1/1000/0/0", done, diff, bout, ovf);
    end
    @(negedge clk);
    a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;             // E5: accepted in the done cycle
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: ready=%b done=%b, want 0/0", ready, done);
    end
    for (int k = 6; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (diff !== 16'h1000 || done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold_e%0d: diff=%h done=%b, want 1000/0", k, diff, done);
      end
    end
    @(posedge clk); #1;             // E9
    checks++;
    if (done !== 1'b1 || diff !== 16'h0002 || bout !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: done=%b diff=%h bout=%b ovf=%b, want 1/0002/0/0", done, diff, bout, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    run_op("pre_rst", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;             // E0
    start = 1'b0;
    @(posedge clk); #1;             // E1
    @(posedge clk); #1;             // E2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({diff, bout, ovf, done} !== 19'd0 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: diff=%h bout=%b ovf=%b done=%b ready=%b busy=%b, want 0/0/0/0/1/0",
               diff, bout, ovf, done, ready, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || ready !== 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL rst_no_done: %0d bad cycles after reset release, want 0", seen_done);
    end
    run_op("post_rst", 16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
